seq_shifter: RTL and testbench

Multi-cycle, parametrised shift unit for the FPU datapath, a successor to the single-bit serial shift register. It accepts an operand and a shift amount over a valid/ready handshake and shifts by up to STEP bits per cycle, either left or right (logical or arithmetic). Right shifts collect guard/round/sticky bits for mantissa alignment and rounding; left shifts flag lost ones for normalisation overflow.

---
 rtl/seq_shifter_pkg.sv | 19 +
 rtl/seq_shifter_shift_step.sv | 69 ++++++
 rtl/seq_shifter.sv | 156 +++++++++++++++
 tb/tb_seq_shifter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared types and constants for the multi-cycle shift unit.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Largest useful shift: once every data bit (and G/R when present) has
  // been replaced by fill, further shifting changes nothing.
  function automatic int clamp_limit(input int width, input bit grs_en);
    return grs_en ? width + 2 : width;
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational one-step shifter: moves the data (and the G/R tail on right
// shifts) by k <= STEP positions and reports what fell off the end.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STEP   = 4,
  parameter bit GRS_EN = 1'b1,
  parameter int KW     = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_g,
  input  logic             i_r,
  input  logic [KW-1:0]    i_k,
  input  logic             i_dir,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data,
  output logic             o_g,
  output logic             o_r,
  output logic             o_sticky,
  output logic             o_ovf
);

  localparam int CW = GRS_EN ? WIDTH + 2 : WIDTH;

  logic [CW-1:0]    w_chain_in;
  logic [CW-1:0]    w_c;
  logic [WIDTH-1:0] w_d;
  logic             w_s;
  logic             w_o;

  generate
    if (GRS_EN) begin : g_grs
      assign w_chain_in = {i_data, i_g, i_r};
      assign o_g        = w_c[1];
      assign o_r        = w_c[0];
    end else begin : g_nogrs
      logic w_unused_gr;
      assign w_unused_gr = i_g ^ i_r;
      assign w_chain_in  = i_data;
      assign o_g         = 1'b0;
      assign o_r         = 1'b0;
    end
  endgenerate

  // Unrolled single-bit shifts; only the first k iterations take effect.
  always_comb begin
    w_c = w_chain_in;
    w_d = i_data;
    w_s = 1'b0;
    w_o = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(i_k)) begin
        if (i_dir == DIR_RIGHT) begin
          w_s = w_s | w_c[0];
          w_c = {i_fill, w_c[CW-1:1]};
        end else begin
          w_o = w_o | w_d[WIDTH-1];
          w_d = {w_d[WIDTH-2:0], i_fill};
        end
      end
    end
  end

  assign o_data   = (i_dir == DIR_RIGHT) ? w_c[CW-1 -: WIDTH] : w_d;
  assign o_sticky = w_s;
  assign o_ovf    = w_o;

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: accepts an operand over valid/ready, shifts up to
// STEP bits per cycle, collects G/R/S on right shifts and lost-one overflow
// on left shifts. Optional feature macro: SEQ_SHIFTER_GRS_EN (G/R/S chain).
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic             in_arith,
  input  logic             in_fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_guard,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_ovf,
  output logic             busy
);

`ifdef SEQ_SHIFTER_GRS_EN
  localparam bit GRS_EN = 1'b1;
`else
  localparam bit GRS_EN = 1'b0;
`endif

  localparam int LIM_R = clamp_limit(WIDTH, GRS_EN);
  localparam int LIM_L = clamp_limit(WIDTH, 1'b1);
  localparam int REM_W = $clog2(WIDTH + 3);
  localparam int KW    = $clog2(STEP + 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_g, r_r, r_s, r_ovf;
  logic             r_dir, r_fill, r_valid;
  logic [REM_W-1:0] r_rem, w_rem_ld;
  logic [KW-1:0]    w_k;
  logic [31:0]      w_amt_ext, w_lim;
  logic             w_accept;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_g_nxt, w_r_nxt, w_sticky, w_ovf;

  assign w_accept  = (r_state == IDLE) && in_valid && !abort;
  assign w_amt_ext = 32'(in_amt);
  assign w_lim     = (in_dir == DIR_LEFT) ? 32'(LIM_L) : 32'(LIM_R);

  // Clamp the requested amount and pick this cycle's step size.
  always_comb begin
    w_rem_ld = REM_W'(w_amt_ext);
    if (w_amt_ext > w_lim) w_rem_ld = REM_W'(w_lim);
    w_k = KW'(r_rem);
    if (r_rem > REM_W'(STEP)) w_k = KW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .GRS_EN(GRS_EN),
    .KW    (KW)
  ) u_step (
    .i_data  (r_data),
    .i_g     (r_g),
    .i_r     (r_r),
    .i_k     (w_k),
    .i_dir   (r_dir),
    .i_fill  (r_fill),
    .o_data  (w_data_nxt),
    .o_g     (w_g_nxt),
    .o_r     (w_r_nxt),
    .o_sticky(w_sticky),
    .o_ovf   (w_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode; abort overrides everything, including a handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = (w_rem_ld == '0) ? DONE : SHIFT;
      SHIFT:   if (r_rem <= REM_W'(STEP)) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // Registered result-valid, mirrors entry into / stay in DONE.
  always_ff @(posedge clk) begin
    if (reset) r_valid <= 1'b0;
    else       r_valid <= (w_state_nxt == DONE);
  end

  // Datapath: load on accept, step while shifting, frozen otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= {1'b1, {(WIDTH-1){1'b0}}};
      r_g    <= 1'b0;
      r_r    <= 1'b0;
      r_s    <= 1'b0;
      r_ovf  <= 1'b0;
      r_dir  <= DIR_RIGHT;
      r_fill <= 1'b0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_dir  <= in_dir;
      r_fill <= (in_dir == DIR_RIGHT && in_arith) ? in_data[WIDTH-1] : in_fill;
      r_rem  <= w_rem_ld;
      r_g    <= 1'b0;
      r_r    <= 1'b0;
      r_s    <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == SHIFT && !abort) begin
      r_data <= w_data_nxt;
      r_g    <= w_g_nxt;
      r_r    <= w_r_nxt;
      r_s    <= r_s | w_sticky;
      r_ovf  <= r_ovf | w_ovf;
      r_rem  <= r_rem - REM_W'(w_k);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ovf   = r_ovf;

`ifdef SEQ_SHIFTER_GRS_EN
  assign out_guard  = r_g;
  assign out_round  = r_r;
  assign out_sticky = r_s;
`else
  logic w_unused_grs;
  assign w_unused_grs = r_g ^ r_r ^ r_s;
  assign out_guard    = 1'b0;
  assign out_round    = 1'b0;
  assign out_sticky   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// Directed vector bench for seq_shifter (WIDTH=32, STEP=4); expectations
// follow whichever G/R/S build is compiled.
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_GRS_EN
  localparam bit GRS = 1'b1;
`else
  localparam bit GRS = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          amt;
    logic        dir;
    logic        arith;
    logic        fill;
    logic [31:0] e_data;
    logic        e_g;
    logic        e_r;
    logic        e_s;
    logic        e_ovf;
    int          e_lat;
  } vec_t;

  logic        clk = 1'b0, reset = 1'b1, abort = 1'b0, in_valid = 1'b0;
  logic        in_dir = 1'b0, in_arith = 1'b0, in_fill = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [7:0]  in_amt = '0;
  logic        in_ready, out_valid, out_guard, out_round, out_sticky, out_ovf, busy;
  logic [31:0] out_data;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[14];

  seq_shifter #(.WIDTH(32), .STEP(4), .AMT_W(8)) dut (
    .clk(clk), .reset(reset), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir), .in_arith(in_arith), .in_fill(in_fill),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int to = 0;
    while (!in_ready && to < 100) begin
      @(posedge clk); #1;
      to++;
    end
    if (!in_ready) chk("wait_idle timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    wait_idle();
    @(negedge clk);
    in_data = v.data; in_amt = 8'(v.amt); in_dir = v.dir;
    in_arith = v.arith; in_fill = v.fill; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    chk($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.e_lat));
    chk($sformatf("v%0d data", idx), out_data, v.e_data);
    chk($sformatf("v%0d guard", idx), 32'(out_guard), 32'(v.e_g));
    chk($sformatf("v%0d round", idx), 32'(out_round), 32'(v.e_r));
    chk($sformatf("v%0d sticky", idx), 32'(out_sticky), 32'(v.e_s));
    chk($sformatf("v%0d ovf", idx), 32'(out_ovf), 32'(v.e_ovf));
  endtask

  initial begin
    //            data          amt  dir arith fill  e_data        G    R    S    ovf  lat
    vecs[0]  = '{32'h8000_0001,   3, 0, 0, 0, 32'h1000_0000, 0,   0,   GRS, 0, 2};
    vecs[1]  = '{32'hF000_0000,   8, 0, 1, 0, 32'hFFF0_0000, 0,   0,   0,   0, 3};
    vecs[2]  = '{32'h4000_0001,   2, 1, 0, 1, 32'h0000_0007, 0,   0,   0,   1, 2};
    vecs[3]  = '{32'h0000_0003, 200, 0, 0, 0, 32'h0000_0000, 0,   0,   GRS, 0, GRS ? 10 : 9};
    vecs[4]  = '{32'h0000_0001,   1, 0, 0, 0, 32'h0000_0000, GRS, 0,   0,   0, 2};
    vecs[5]  = '{32'h0000_0003,   2, 0, 0, 0, 32'h0000_0000, GRS, GRS, 0,   0, 2};
    vecs[6]  = '{32'hFFFF_FFFF,  33, 0, 0, 0, 32'h0000_0000, 0,   GRS, GRS, 0, GRS ? 10 : 9};
    vecs[7]  = '{32'h8000_0001,   4, 1, 1, 0, 32'h0000_0010, 0,   0,   0,   1, 2};
    vecs[8]  = '{32'h7000_0000,   4, 0, 1, 0, 32'h0700_0000, 0,   0,   0,   0, 2};
    vecs[9]  = '{32'h0000_0001, 200, 1, 0, 1, 32'hFFFF_FFFF, 0,   0,   0,   1, 10};
    vecs[10] = '{32'h0000_0000,   5, 0, 0, 1, 32'hF800_0000, 0,   0,   0,   0, 3};
    vecs[11] = '{32'h0000_FFFF,  16, 1, 0, 0, 32'hFFFF_0000, 0,   0,   0,   0, 5};
    vecs[12] = '{32'h0000_0010,   4, 0, 0, 0, 32'h0000_0001, 0,   0,   0,   0, 2};
    vecs[13] = '{32'h0000_000F,  32, 0, 0, 0, 32'h0000_0000, 0,   0,   GRS, 0, 9};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_data", out_data, 32'h8000_0000);
    chk("rst grs_ovf", {28'd0, out_guard, out_round, out_sticky, out_ovf}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // amt 0 with back-pressure: result held, no new accept
    wait_idle();
    @(negedge clk);
    out_ready = 1'b0;
    in_data = 32'h1234_5678; in_amt = 8'd0; in_dir = 1'b0;
    in_arith = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold lat1 valid", 32'(out_valid), 32'd1);
    chk("hold lat1 data", out_data, 32'h1234_5678);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold c%0d valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold c%0d data", c), out_data, 32'h1234_5678);
      chk($sformatf("hold c%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    chk("hold release valid", 32'(out_valid), 32'd0);

    // abort in the second SHIFT cycle of a 16-bit right shift
    @(negedge clk);
    in_data = 32'hFFFF_0000; in_amt = 8'd16; in_dir = 1'b0;
    in_arith = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort data frozen", out_data, 32'h0FFF_F000);

    // abort coinciding with a handshake drops the operand
    @(negedge clk);
    in_data = 32'hDEAD_BEEF; in_amt = 8'd0; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    chk("abort+hs in_ready", 32'(in_ready), 32'd1);
    chk("abort+hs out_valid", 32'(out_valid), 32'd0);
    chk("abort+hs data", out_data, 32'h0FFF_F000);

    // left op to set ovf, then reset mid-operation
    run_vec(vecs[2], 2);
    wait_idle();
    @(negedge clk);
    in_data = 32'hFFFF_0000; in_amt = 8'd16; in_dir = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst out_data", out_data, 32'h8000_0000);
    chk("midrst grs_ovf", {28'd0, out_guard, out_round, out_sticky, out_ovf}, 32'd0);

    run_vec(vecs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
